// File: rtl/tinyarch_pkg.sv
// Shared tinyarch definitions: default datapath widths and the fetch FSM encoding.
package tinyarch_pkg;
    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: drives a synchronous ROM, presents its data with zero bubbles,
// handles stall/branch/halt and counts retired instructions (saturating).
module fetch_unit
    import tinyarch_pkg::*;
#(
    parameter int PC_W    = tinyarch_pkg::PC_W,
    parameter int INSTR_W = tinyarch_pkg::INSTR_W,
    parameter int CNT_W   = tinyarch_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               halt_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic               done,
    output logic [CNT_W-1:0]   retired
);

    fetch_state_t      state;
    logic [PC_W-1:0]   next_addr;
    logic [CNT_W-1:0]  retired_inc;

    // The address issued now is what pc becomes at the edge, so pc always
    // names the word the ROM returns on the following cycle.
    always_comb begin
        next_addr = '0;
        case (state)
            RUN: begin
                if (stall || halt_req) next_addr = pc;
                else if (branch_taken) next_addr = branch_target;
                else                   next_addr = pc + PC_W'(1);
            end
            HALTED:  next_addr = start ? '0 : pc;
            default: next_addr = '0;
        endcase
    end

    assign imem_addr   = next_addr;
    assign instr       = imem_rdata;
    assign instr_valid = (state == RUN);
    assign retired_inc = (retired == {CNT_W{1'b1}}) ? retired : retired + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= '0;
            retired <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    pc <= next_addr;
                    if (!stall) begin
                        retired <= retired_inc;
                        if (halt_req) begin
                            state <= HALTED;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state   <= RUN;
                        pc      <= '0;
                        retired <= '0;
                        done    <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// against a cycle-level behavioural model and a ROM array.
module tb_fetch_unit;
    localparam int PC_W = 10;
    localparam int INSTR_W = 9;
    localparam int SAT_MAX = 15;

    logic clk = 0;
    logic rst_n = 0;
    logic start = 0, stall = 0, branch_taken = 0, halt_req = 0;
    logic [PC_W-1:0] branch_target = '0;

    logic [PC_W-1:0]    imem_addr, pc, imem_addr_s, pc_s;
    logic [INSTR_W-1:0] imem_rdata = '0, instr, imem_rdata_s = '0, instr_s;
    logic               instr_valid, done, instr_valid_s, done_s;
    logic [15:0]        retired;
    logic [3:0]         retired_s;

    logic [INSTR_W-1:0] rom [1<<PC_W];

    int checks = 0, errors = 0;
    // reference model: 0 idle, 1 running, 2 halted
    int m_state = 0, m_pc = 0, m_cnt = 0;

    always #5 clk = ~clk;

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .halt_req(halt_req),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .pc(pc), .done(done), .retired(retired));

    // narrow-counter twin, same stimulus, to reach saturation quickly
    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .halt_req(halt_req),
        .imem_addr(imem_addr_s), .imem_rdata(imem_rdata_s), .instr(instr_s),
        .instr_valid(instr_valid_s), .pc(pc_s), .done(done_s), .retired(retired_s));

    always @(posedge clk) begin
        imem_rdata   <= rom[imem_addr];
        imem_rdata_s <= rom[imem_addr_s];
    end

    function automatic int exp_ret();
        return (m_cnt > 65535) ? 65535 : m_cnt;
    endfunction

    function automatic int exp_ret_s();
        return (m_cnt > SAT_MAX) ? SAT_MAX : m_cnt;
    endfunction

    // Advance one clock and apply the spec rules to the model with the inputs held across the edge.
    task automatic step();
        @(posedge clk);
        if (start && m_state != 1) begin
            m_state = 1; m_pc = 0; m_cnt = 0;
        end else if (m_state == 1 && !stall) begin
            m_cnt++;
            if (halt_req)          m_state = 2;
            else if (branch_taken) m_pc = int'(branch_target);
            else                   m_pc = (m_pc + 1) % (1 << PC_W);
        end
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; stall = 0; branch_taken = 0; halt_req = 0; branch_target = '0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (pc !== 0 || instr_valid !== 0 || done !== 0 || retired !== 0 || imem_addr !== 0) begin
            errors++;
            $display("FAIL reset_state: pc=%0h valid=%0b done=%0b retired=%0d addr=%0h, want all 0",
                     pc, instr_valid, done, retired, imem_addr);
        end
        @(negedge clk); rst_n = 1;
        step(); step();
        checks++;
        if (instr_valid !== 0 || imem_addr !== 0) begin
            errors++;
            $display("FAIL idle_no_start: valid=%0b addr=%0h, want 0/0", instr_valid, imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [INSTR_W-1:0] e [4];
        e = '{9'h011, 9'h022, 9'h033, 9'h044};
        start = 1; step(); start = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pc !== PC_W'(i) || instr !== e[i] || instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL seq_fetch[%0d]: pc=%0h instr=%0h valid=%0b, want pc=%0h instr=%0h valid=1",
                         i, pc, instr, instr_valid, i, e[i]);
            end
            step();
        end
    endtask

    task automatic test_stall();
        int r0;
        branch_taken = 1; branch_target = 10'd2; step(); clear_inputs();
        r0 = int'(retired);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc !== 10'd2 || instr !== 9'h033 || int'(retired) != r0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: pc=%0h instr=%0h retired=%0d, want 2/033/%0d",
                         i, pc, instr, retired, r0);
            end
        end
        stall = 0; step();
        checks++;
        if (pc !== 10'd3 || int'(retired) != r0 + 1) begin
            errors++;
            $display("FAIL stall_release: pc=%0h retired=%0d, want 3/%0d", pc, retired, r0 + 1);
        end
        stall = 1; branch_taken = 1; branch_target = 10'h055; halt_req = 1; step(); clear_inputs();
        checks++;
        if (pc !== 10'd3 || done !== 0 || instr_valid !== 1) begin
            errors++;
            $display("FAIL stall_ignores_ctrl: pc=%0h done=%0b valid=%0b, want 3/0/1", pc, done, instr_valid);
        end
    endtask

    task automatic test_branch();
        branch_taken = 1; branch_target = 10'd5; step();
        branch_target = 10'h120; step(); clear_inputs();
        checks++;
        if (pc !== 10'h120 || instr !== rom[10'h120]) begin
            errors++;
            $display("FAIL branch_redirect: pc=%0h instr=%0h, want 120/%0h", pc, instr, rom[10'h120]);
        end
    endtask

    task automatic test_wrap();
        branch_taken = 1; branch_target = 10'h3FF; step(); clear_inputs();
        step();
        checks++;
        if (pc !== 10'h000 || instr !== 9'h011) begin
            errors++;
            $display("FAIL pc_wrap: pc=%0h instr=%0h, want 000/011", pc, instr);
        end
    endtask

    task automatic test_halt();
        halt_req = 1; step(); clear_inputs();
        start = 1; step(); start = 0;
        repeat (7) step();
        halt_req = 1; branch_taken = 1; branch_target = 10'h099; step(); clear_inputs();
        checks++;
        if (done !== 1 || retired !== 16'd8 || pc !== 10'd7 || instr_valid !== 0) begin
            errors++;
            $display("FAIL halt_enter: done=%0b retired=%0d pc=%0h valid=%0b, want 1/8/7/0",
                     done, retired, pc, instr_valid);
        end
        repeat (3) step();
        checks++;
        if (done !== 1 || retired !== 16'd8 || pc !== 10'd7 || imem_addr !== 10'd7) begin
            errors++;
            $display("FAIL halt_hold: done=%0b retired=%0d pc=%0h addr=%0h, want 1/8/7/7",
                     done, retired, pc, imem_addr);
        end
        start = 1; step(); start = 0;
        checks++;
        if (pc !== 0 || retired !== 0 || done !== 0 || instr_valid !== 1 || instr !== 9'h011) begin
            errors++;
            $display("FAIL halt_restart: pc=%0h retired=%0d done=%0b valid=%0b instr=%0h, want 0/0/0/1/011",
                     pc, retired, done, instr_valid, instr);
        end
    endtask

    task automatic test_saturate();
        repeat (20) step();
        checks++;
        if (int'(retired) != exp_ret() || int'(retired_s) != SAT_MAX) begin
            errors++;
            $display("FAIL retired_saturate: wide=%0d narrow=%0d, want %0d/%0d",
                     retired, retired_s, exp_ret(), SAT_MAX);
        end
        repeat (3) step();
        checks++;
        if (int'(retired_s) != SAT_MAX) begin
            errors++;
            $display("FAIL retired_sat_hold: narrow=%0d, want %0d", retired_s, SAT_MAX);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); #2 rst_n = 0; #1;
        m_state = 0; m_pc = 0; m_cnt = 0;
        checks++;
        if (pc !== 0 || instr_valid !== 0 || imem_addr !== 0 || retired !== 0 || done !== 0 || retired_s !== 0) begin
            errors++;
            $display("FAIL async_reset: pc=%0h valid=%0b addr=%0h retired=%0d done=%0b, want all 0",
                     pc, instr_valid, imem_addr, retired, done);
        end
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (instr_valid !== 0 || pc !== 0 || imem_addr !== 0) begin
                errors++;
                $display("FAIL reset_stays_idle[%0d]: valid=%0b pc=%0h addr=%0h, want 0", i, instr_valid, pc, imem_addr);
            end
        end
    endtask

    task automatic test_random();
        int bad = 0;
        start = 1; step(); start = 0;
        for (int i = 0; i < 400; i++) begin
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 4) == 0);
            branch_target = PC_W'($urandom);
            halt_req      = ($urandom_range(0, 39) == 0);
            start         = ($urandom_range(0, 7) == 0);
            step();
            checks++;
            if (int'(pc) != m_pc || instr_valid !== (m_state == 1) || done !== (m_state == 2) ||
                int'(retired) != exp_ret() || int'(retired_s) != exp_ret_s() ||
                (m_state == 1 && instr !== rom[m_pc])) begin
                errors++;
                if (bad++ < 5)
                    $display("FAIL random[%0d]: pc=%0h valid=%0b done=%0b retired=%0d instr=%0h, want pc=%0h state=%0d retired=%0d",
                             i, pc, instr_valid, done, retired, instr, m_pc, m_state, exp_ret());
            end
        end
        clear_inputs();
    endtask

    initial begin
        for (int a = 0; a < (1 << PC_W); a++) rom[a] = INSTR_W'($urandom);
        rom[0] = 9'h011; rom[1] = 9'h022; rom[2] = 9'h033; rom[3] = 9'h044;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_wrap();
        test_halt();
        test_saturate();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 10, program-counter and instruction-memory address width.
REQ-002 Parameter INSTR_W, default 9, instruction width.
REQ-003 Parameter CNT_W, default 16, retired-instruction counter width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin execution at PC 0.
REQ-007 stall  input  1  downstream cannot accept the current instruction this cycle.
REQ-008 branch_taken  input  1  current instruction redirects the PC.
REQ-009 branch_target  input  PC_W  redirect address.
REQ-010 halt_req  input  1  current instruction is the program-end instruction.
REQ-011 imem_addr  output  PC_W  address to synchronous instruction ROM; sampled at the clock edge.
REQ-012 imem_rdata  input  INSTR_W  ROM data for the address sampled at the previous edge.
REQ-013 instr  output  INSTR_W  current instruction to decode and operand-select logic.
REQ-014 instr_valid  output  1  instr is a live instruction.
REQ-015 pc  output  PC_W  address of the instruction on instr.
REQ-016 done  output  1  program has halted.
REQ-017 retired  output  CNT_W  count of retired instructions since the last start.

Function
REQ-018 FSM states SHALL be IDLE, RUN and HALTED.
REQ-019 IDLE: imem_addr = 0, instr_valid = 0, done = 0; start -> RUN, pc <= 0, retired <= 0.
REQ-020 RUN: instr SHALL equal imem_rdata (pass-through), instr_valid = 1, so ROM[pc] is presented the cycle after entry with zero bubbles.
REQ-021 An instruction retires in a cycle where state = RUN and stall = 0.
REQ-022 RUN next-address priority: stall -> pc (re-read, instr held); else halt_req -> pc; else branch_taken -> branch_target; else pc + 1 modulo 2^PC_W.
REQ-023 pc SHALL load imem_addr at every edge while in RUN, so pc always names the data on imem_rdata.
REQ-024 halt_req with stall = 0 -> HALTED next cycle; halt_req SHALL take priority over branch_taken in the same cycle.
REQ-025 halt_req, branch_taken and branch_target SHALL be ignored while stall = 1.
REQ-026 HALTED: done = 1, instr_valid = 0, pc and retired held, imem_addr = pc.
REQ-027 start in HALTED SHALL behave as in IDLE (RUN, pc <= 0, retired <= 0, done deasserts next cycle).
REQ-028 start in RUN SHALL be ignored.
REQ-029 retired SHALL increment by 1 per retiring instruction, including the halting one, and saturate at 2^CNT_W - 1.
REQ-030 PC wrap: pc = 2^PC_W - 1 with no branch SHALL fetch address 0 next.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, pc 0, retired 0, done 0, instr_valid 0, imem_addr 0, regardless of clk.
REQ-032 Reset asserted mid-RUN SHALL discard the in-flight fetch; release SHALL require a new start.
REQ-033 Release of rst_n SHALL take effect at the first rising clk edge after deassertion.

Structure
REQ-034 PC_W, INSTR_W and the fetch_state_t enum (IDLE, RUN, HALTED) SHALL live in the shared tinyarch package.
REQ-035 No sub-module is required; next-PC mux, FSM and saturating counter SHALL be inline.

Verification
REQ-036 Reset, start, ROM[0..3] = 9'h011/9'h022/9'h033/9'h044, no stalls -> pc 0,1,2,3 on consecutive cycles with matching instr, instr_valid = 1 from the first RUN cycle.
REQ-037 stall high 3 cycles at pc = 2 -> pc = 2, instr = 9'h033 held for 3 cycles, retired unchanged during the stall, then pc = 3.
REQ-038 branch_taken with branch_target = 10'h120 at pc = 5 -> next pc = 10'h120; branch_taken with stall = 1 -> ignored.
REQ-039 halt_req with branch_taken at pc = 7 after 8 retires -> HALTED, done = 1, retired = 8, pc = 7 held; start -> pc = 0, retired = 0, done = 0.
REQ-040 pc = 10'h3FF without branch -> next pc = 10'h000; rst_n pulsed low mid-RUN -> outputs clear asynchronously and stay IDLE until start.
REQ-041 Force retired to 16'hFFFE and retire 3 instructions -> retired = 16'hFFFF and held.
